// File: rtl/xalu_pkg.sv
// Shared op codes, latencies and the 64-bit HI/LO result function for the execute-stage mul/div unit.
// XALU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU family on op 7.
package xalu_pkg;

  localparam logic [2:0] XALU_NOP   = 3'd0;
  localparam logic [2:0] XALU_MULT  = 3'd1;
  localparam logic [2:0] XALU_MULTU = 3'd2;
  localparam logic [2:0] XALU_DIV   = 3'd3;
  localparam logic [2:0] XALU_DIVU  = 3'd4;
  localparam logic [2:0] XALU_MTHI  = 3'd5;
  localparam logic [2:0] XALU_MTLO  = 3'd6;
  localparam logic [2:0] XALU_MADD  = 3'd7;

  localparam logic [1:0] XALU_SEL_MADD  = 2'd0;
  localparam logic [1:0] XALU_SEL_MADDU = 2'd1;
  localparam logic [1:0] XALU_SEL_MSUB  = 2'd2;
  localparam logic [1:0] XALU_SEL_MSUBU = 2'd3;

  localparam int unsigned XALU_MUL_LAT_DEF = 5;
  localparam int unsigned XALU_DIV_LAT_DEF = 10;

  function automatic logic xalu_is_long(input logic [2:0] op);
    case (op)
      XALU_MULT, XALU_MULTU, XALU_DIV, XALU_DIVU: return 1'b1;
`ifdef XALU_MADD_EN
      XALU_MADD: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic xalu_is_mul(input logic [2:0] op);
    return (op == XALU_MULT) || (op == XALU_MULTU) || (op == XALU_MADD);
  endfunction

  // Returns {HI,LO}; ops that do not produce a 64-bit result return the current {HI,LO}.
  function automatic logic [63:0] xalu_calc(input logic [2:0] op, input logic [1:0] msel,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [63:0] acc;
    logic [63:0] res;
    logic [31:0] q;
    logic [31:0] r;
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    acc   = {hi, lo};
    res   = acc;
    q     = '0;
    r     = '0;
    case (op)
      XALU_MULT:  res = sprod;
      XALU_MULTU: res = uprod;
      XALU_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      XALU_DIVU: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q   = a / b;
          r   = a % b;
          res = {r, q};
        end
      end
      XALU_MADD: begin
        case (msel)
          XALU_SEL_MADD:  res = acc + sprod;
          XALU_SEL_MADDU: res = acc + uprod;
          XALU_SEL_MSUB:  res = acc - sprod;
          default:        res = acc - uprod;
        endcase
      end
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xalu_muldiv_if.sv
// Issue/read bundle between the E stage and the mul/div unit.
// XALU_MADD_EN adds the madd_sel sub-select field.
interface xalu_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic [31:0] out;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef XALU_MADD_EN
  logic [1:0]  madd_sel;

  modport master (output start, op, a, b, rd_hi, madd_sel,
                  input  out, busy, stall_req, hi, lo);
  modport slave  (input  start, op, a, b, rd_hi, madd_sel,
                  output out, busy, stall_req, hi, lo);
`else
  modport master (output start, op, a, b, rd_hi,
                  input  out, busy, stall_req, hi, lo);
  modport slave  (input  start, op, a, b, rd_hi,
                  output out, busy, stall_req, hi, lo);
`endif
endinterface

// File: rtl/xalu_latency_ctr.sv
// 4-bit down-counter holding busy for a loaded number of cycles; done marks the final busy cycle.
module xalu_latency_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       busy,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == 4'd1) begin
        count <= 4'd0;
        busy  <= 1'b0;
      end else begin
        count <= count - 4'd1;
      end
    end
  end

  assign done = busy && (count == 4'd1);

endmodule

// File: rtl/xalu_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO; fixed-latency long ops, single-cycle MTHI/MTLO.
// XALU_MADD_EN enables the multiply-accumulate family on op 7 (otherwise op 7 is a NOP).
module xalu_muldiv
  import xalu_pkg::*;
#(
  parameter int unsigned MUL_LAT = XALU_MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = XALU_DIV_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  xalu_muldiv_if.slave  bus
);

  localparam logic [3:0] MUL_LAT4 = 4'(MUL_LAT);
  localparam logic [3:0] DIV_LAT4 = 4'(DIV_LAT);

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_q;
  logic        busy;
  logic        done;
  logic        accept;
  logic        long_op;
  logic        load;
  logic [1:0]  msel;
  logic [3:0]  lat_sel;

`ifdef XALU_MADD_EN
  assign msel = bus.madd_sel;
`else
  assign msel = XALU_SEL_MADD;
`endif

  // A start while busy is dropped entirely; the hazard unit normally prevents it.
  assign accept  = bus.start && !busy;
  assign long_op = xalu_is_long(bus.op);
  assign load    = accept && long_op;
  assign lat_sel = xalu_is_mul(bus.op) ? MUL_LAT4 : DIV_LAT4;

  xalu_latency_ctr u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (lat_sel),
    .busy     (busy),
    .done     (done)
  );

  // The result is computed at acceptance and only committed on the final busy edge,
  // so HI/LO stay architecturally stable for the whole operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= 64'd0;
    end else begin
      if (done) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end else if (accept && bus.op == XALU_MTHI) begin
        hi_q <= bus.a;
      end else if (accept && bus.op == XALU_MTLO) begin
        lo_q <= bus.a;
      end
      if (load) begin
        pend_q <= xalu_calc(bus.op, msel, bus.a, bus.b, hi_q, lo_q);
      end
    end
  end

  assign bus.out       = bus.rd_hi ? hi_q : lo_q;
  assign bus.busy      = busy;
  assign bus.stall_req = busy || (bus.start && long_op);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
